uart_frame_packer: RTL and testbench
====================================

Name: uart_frame_packer

Overview:
Parametrised successor to the single-channel UART word sender. It pulls DATA_W-bit words from the pixel FIFO, splits each into bytes (MSB first) behind an optional sync header byte, and drives the existing uarttx byte transmitter. Pacing is a wrsig/idle handshake plus a minimum inter-byte gap. Frames are bounded: a start pulse arms a frame of FRAME_WORDS words; the block then reports completion, or streams continuously when FRAME_WORDS = 0.

Parameters:
DATA_W, 24, FIFO word width; multiple of 8, range 8..64; BYTES = DATA_W/8.
HDR_EN, 1, 1 = prepend header byte to every word.
HDR_BYTE, 8'h55, header value.
FRAME_WORDS, 2000, words per frame; 0 = continuous, no frame_done.
GAP_CYCLES, 170, minimum UART_CLK cycles from one wrsig pulse to the next; >= 4.
CNT_W, 16, width of word_cnt.

Ports:
UART_CLK  in  1  sole clock (16x baud domain)
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle frame trigger; honoured only in S_IDLE
abort  in  1  level; end the frame after the byte in flight
fifo_empty  in  1  FIFO empty flag
fifo_q  in  DATA_W  FIFO read data, valid one cycle after fifo_rdreq
fifo_rdreq  out  1  one-cycle FIFO read strobe
tx_idle  in  1  from uarttx; high = busy, low = free
tx_data  out  8  byte to uarttx
tx_wrsig  out  1  one-cycle uarttx write enable
busy  out  1  high in every state except S_IDLE
frame_done  out  1  one-cycle pulse at frame end
underflow  out  1  sticky; set when the FIFO is empty at a word boundary mid-frame; cleared by start
word_cnt  out  CNT_W  words completed in the current frame

Behaviour:
- Reset (rst low, async): state S_IDLE; all outputs 0; shift register, byte index and gap counter 0.
- S_IDLE: on start, clear word_cnt and underflow, then go to S_FETCH.
- S_FETCH:
  - If abort, go to S_IDLE with no frame_done.
  - If !fifo_empty, assert fifo_rdreq for exactly one cycle, then go to S_LATCH.
  - If fifo_empty, stay; set underflow if word_cnt != 0. No timeout.
- S_LATCH: capture fifo_q into the shift register. Set byte index to 0 when HDR_EN, else 1. Go to S_ISSUE.
- S_ISSUE:
  - Enter only when tx_idle == 0 and gap counter >= GAP_CYCLES-1, or this is the first byte of the frame; otherwise hold.
  - On entry, drive tx_data: HDR_BYTE when index == 0, else word byte (index-1), MSB first.
  - tx_wrsig = 1 for one cycle; gap counter restarts at 0; go to S_WAIT.
  - tx_data stays stable from the wrsig cycle until the next S_ISSUE.
- S_WAIT: gap counter increments and saturates at GAP_CYCLES-1.
  - Index < BYTES: increment index, go to S_ISSUE.
  - Index == BYTES: word complete; word_cnt += 1.
    - If FRAME_WORDS != 0 and word_cnt+1 == FRAME_WORDS: frame_done pulse, go to S_IDLE.
    - Else if abort: go to S_IDLE, no frame_done.
    - Else: go to S_FETCH.
- Inter-byte spacing is >= GAP_CYCLES cycles, including across word boundaries; a FIFO fetch never shortens the gap.
- Continuous mode (FRAME_WORDS = 0): word_cnt wraps modulo 2^CNT_W; no frame_done.
- A start pulse outside S_IDLE is ignored.
- Simultaneous frame completion and abort: frame_done wins.
- An async reset mid-byte leaves uarttx to finish on its own; the block restarts in S_IDLE.
- FIFO read-ahead is forbidden: no word is ever read without being fully sent.

Decomposition:
- Shared package: state encoding (S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_WAIT) and the default header constant 8'h55.
- Sub-module uart_gap_timer: saturating gap counter with restart input and "gap_met" output.
- uarttx remains external and is instantiated beside this block at top level.

Test Plan:
- DATA_W=24, HDR_EN=1, FRAME_WORDS=2, FIFO preloaded 0xA1B2C3, 0x0D0E0F, start -> tx bytes 55 A1 B2 C3 55 0D 0E 0F; 2 fifo_rdreq pulses; frame_done once; word_cnt=2.
- Same frame, tx_idle model busy for 160 cycles after each wrsig -> every wrsig spacing >= 170 cycles, measured cycle-exact.
- DATA_W=32, HDR_EN=0, FIFO word 0x11223344 -> bytes 11 22 33 44 only; no header byte.
- FIFO empty for 500 cycles after word 1 of a 3-word frame -> underflow=1, no tx_wrsig during the stall, frame resumes and completes.
- abort raised during byte 2 of word 1 -> bytes 2..3 still sent, then S_IDLE; no frame_done; busy=0.
- rst low while in S_WAIT -> all outputs 0 asynchronously; a new start sends from the header again.

Source files
------------

// File: rtl/uart_frame_packer_pkg.sv
// Shared types for the UART frame packer.
// Holds the FSM state encoding and the default sync header byte.
package uart_frame_packer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'h55;

endpackage

// File: rtl/uart_frame_packer_gap.sv
// Saturating inter-byte gap counter.
// Ports: clk, rst (async low), restart (zero the count), gap_met (count at top).
module uart_gap_timer #(
  parameter int GAP_CYCLES = 170
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic gap_met
);

  localparam int W = $clog2(GAP_CYCLES);
  localparam logic [W-1:0] TOP = W'(GAP_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (cnt != TOP) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign gap_met = (cnt == TOP);

endmodule

// File: rtl/uart_frame_packer.sv
// Splits FIFO words into bytes (optional header first) for uarttx.
// Ports: UART_CLK, rst, start, abort, fifo_* , tx_* , busy, frame_done, underflow, word_cnt.
module uart_frame_packer
  import uart_frame_packer_pkg::*;
#(
  parameter int         DATA_W      = 24,
  parameter int         HDR_EN      = 1,
  parameter logic [7:0] HDR_BYTE    = HDR_DEFAULT,
  parameter int         FRAME_WORDS = 2000,
  parameter int         GAP_CYCLES  = 170,
  parameter int         CNT_W       = 16
) (
  input  logic              UART_CLK,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_q,
  output logic              fifo_rdreq,
  input  logic              tx_idle,
  output logic [7:0]        tx_data,
  output logic              tx_wrsig,
  output logic              busy,
  output logic              frame_done,
  output logic              underflow,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int BYTES = DATA_W / 8;
  localparam int IW    = $clog2(BYTES + 1);

  state_t            state, next;
  logic [DATA_W-1:0] shreg;
  logic [IW-1:0]     idx;
  logic              first;
  logic              go;
  logic              gap_met;
  logic              last_byte;
  logic              last_word;

  uart_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap (
    .clk    (UART_CLK),
    .rst    (rst),
    .restart(go),
    .gap_met(gap_met)
  );

  assign last_byte = (idx == IW'(BYTES));
  assign last_word = (FRAME_WORDS != 0) &&
                     (word_cnt == CNT_W'(FRAME_WORDS - 1));
  assign busy      = (state != S_IDLE);

  always_ff @(posedge UART_CLK or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next;
  end

  // First byte of a frame skips the gap; uarttx must still be free.
  always_comb begin
    next       = state;
    fifo_rdreq = 1'b0;
    frame_done = 1'b0;
    go         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) next = S_FETCH;
      end
      S_FETCH: begin
        if (abort) begin
          next = S_IDLE;
        end else if (!fifo_empty) begin
          fifo_rdreq = 1'b1;
          next       = S_LATCH;
        end
      end
      S_LATCH: next = S_ISSUE;
      S_ISSUE: begin
        if (!tx_idle && (gap_met || first)) begin
          go   = 1'b1;
          next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!last_byte) begin
          next = S_ISSUE;
        end else if (last_word) begin
          frame_done = 1'b1;
          next       = S_IDLE;
        end else if (abort) begin
          next = S_IDLE;
        end else begin
          next = S_FETCH;
        end
      end
      default: next = S_IDLE;
    endcase
  end

  // tx_data and tx_wrsig register together on go so data is
  // already stable in the wrsig cycle.
  always_ff @(posedge UART_CLK or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      idx       <= '0;
      first     <= 1'b0;
      tx_data   <= '0;
      tx_wrsig  <= 1'b0;
      word_cnt  <= '0;
      underflow <= 1'b0;
    end else begin
      tx_wrsig <= go;
      if (state == S_IDLE && start) begin
        word_cnt  <= '0;
        underflow <= 1'b0;
        first     <= 1'b1;
      end
      if (state == S_FETCH && !abort && fifo_empty &&
          word_cnt != '0) begin
        underflow <= 1'b1;
      end
      if (state == S_LATCH) begin
        shreg <= fifo_q;
        idx   <= (HDR_EN != 0) ? IW'(0) : IW'(1);
      end
      if (go) begin
        first <= 1'b0;
        if (idx == '0) begin
          tx_data <= HDR_BYTE;
        end else begin
          tx_data <= shreg[DATA_W-1 -: 8];
          shreg   <= shreg << 8;
        end
      end
      if (state == S_WAIT) begin
        if (!last_byte) idx <= idx + 1'b1;
        else            word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Scoreboard bench for uart_frame_packer.
// Two instances: 24-bit with header, 32-bit without header.
module tb_uart_frame_packer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int     n_chk  = 0;
  int     n_fail = 0;
  longint cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ge(string nm, longint act, longint lim);
    n_chk++;
    if (act < lim) begin
      n_fail++;
      $display("FAIL %s: got %0d expected >= %0d", nm, act, lim);
    end
  endtask

  // ---------------- instance A: 24 bit, header, 2 words
  logic        startA = 0, abortA = 0;
  logic        emptyA, rdA, idleA, wrA, busyA, doneA, ufA;
  logic [23:0] qA = '0;
  logic [7:0]  txA;
  logic [15:0] wcA;
  logic [23:0] fifoA[$];
  logic [7:0]  sbA[$];
  int          pushA = 0, popA = 0, bcA = 0;
  int          wrcA = 0, rdcA = 0, dcA = 0;
  longint      lastA = -1;

  assign emptyA = (pushA == popA);
  assign idleA  = (bcA != 0);

  uart_frame_packer #(
    .DATA_W(24), .HDR_EN(1), .HDR_BYTE(8'h55),
    .FRAME_WORDS(2), .GAP_CYCLES(170), .CNT_W(16)
  ) dutA (
    .UART_CLK(clk), .rst(rst), .start(startA), .abort(abortA),
    .fifo_empty(emptyA), .fifo_q(qA), .fifo_rdreq(rdA),
    .tx_idle(idleA), .tx_data(txA), .tx_wrsig(wrA),
    .busy(busyA), .frame_done(doneA), .underflow(ufA),
    .word_cnt(wcA)
  );

  always @(posedge clk) begin
    if (rdA && fifoA.size() > 0) begin
      qA <= fifoA.pop_front();
      popA <= popA + 1;
    end
    if (wrA) bcA <= 160;
    else if (bcA != 0) bcA <= bcA - 1;
  end

  always @(negedge clk) begin
    if (rdA) rdcA++;
    if (doneA) dcA++;
    if (wrA) begin
      wrcA++;
      chk("A_sb_avail", sbA.size() != 0, 1);
      if (sbA.size() != 0) chk("A_byte", txA, sbA.pop_front());
      if (lastA >= 0) chk_ge("A_gap", cyc - lastA, 170);
      lastA = cyc;
    end
  end

  // ---------------- instance B: 32 bit, no header, 3 words
  logic        startB = 0, abortB = 0;
  logic        emptyB, rdB, idleB, wrB, busyB, doneB, ufB;
  logic [31:0] qB = '0;
  logic [7:0]  txB;
  logic [15:0] wcB;
  logic [31:0] fifoB[$];
  logic [7:0]  sbB[$];
  int          pushB = 0, popB = 0, bcB = 0;
  int          wrcB = 0, rdcB = 0, dcB = 0;
  longint      lastB = -1;

  assign emptyB = (pushB == popB);
  assign idleB  = (bcB != 0);

  uart_frame_packer #(
    .DATA_W(32), .HDR_EN(0), .HDR_BYTE(8'h55),
    .FRAME_WORDS(3), .GAP_CYCLES(8), .CNT_W(16)
  ) dutB (
    .UART_CLK(clk), .rst(rst), .start(startB), .abort(abortB),
    .fifo_empty(emptyB), .fifo_q(qB), .fifo_rdreq(rdB),
    .tx_idle(idleB), .tx_data(txB), .tx_wrsig(wrB),
    .busy(busyB), .frame_done(doneB), .underflow(ufB),
    .word_cnt(wcB)
  );

  always @(posedge clk) begin
    if (rdB && fifoB.size() > 0) begin
      qB <= fifoB.pop_front();
      popB <= popB + 1;
    end
    if (wrB) bcB <= 5;
    else if (bcB != 0) bcB <= bcB - 1;
  end

  always @(negedge clk) begin
    if (rdB) rdcB++;
    if (doneB) dcB++;
    if (wrB) begin
      wrcB++;
      chk("B_sb_avail", sbB.size() != 0, 1);
      if (sbB.size() != 0) chk("B_byte", txB, sbB.pop_front());
      if (lastB >= 0) chk_ge("B_gap", cyc - lastB, 8);
      lastB = cyc;
    end
  end

  // ---------------- stimulus helpers
  task automatic fA(logic [23:0] w);
    fifoA.push_back(w);
    pushA++;
  endtask

  task automatic eA(logic [23:0] w);
    sbA.push_back(8'h55);
    sbA.push_back(w[23:16]);
    sbA.push_back(w[15:8]);
    sbA.push_back(w[7:0]);
  endtask

  task automatic wB(logic [31:0] w);
    fifoB.push_back(w);
    pushB++;
    sbB.push_back(w[31:24]);
    sbB.push_back(w[23:16]);
    sbB.push_back(w[15:8]);
    sbB.push_back(w[7:0]);
  endtask

  task automatic pulseA();
    @(negedge clk);
    lastA = -1;
    startA = 1;
    @(negedge clk);
    startA = 0;
  endtask

  task automatic pulseB();
    @(negedge clk);
    lastB = -1;
    startB = 1;
    @(negedge clk);
    startB = 0;
  endtask

  task automatic idleA_wait(string nm);
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (!busyA) break;
    end
    chk(nm, busyA, 0);
  endtask

  task automatic idleB_wait(string nm);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busyB) break;
    end
    chk(nm, busyB, 0);
  endtask

  // Returns just after the n-th wrsig edge, while A sits in S_WAIT.
  task automatic wrA_wait(string nm, int n);
    int c = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if (wrA) c++;
      if (c == n) break;
    end
    chk(nm, c, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int r0, d0, w0;

  initial begin
    // reset state
    #12;
    chk("rst_busy", busyA, 0);
    chk("rst_wrsig", wrA, 0);
    chk("rst_rdreq", rdA, 0);
    chk("rst_txdata", txA, 0);
    chk("rst_wcnt", wcA, 0);
    chk("rst_uf", ufA, 0);
    chk("rst_done", doneA, 0);
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);

    // A: two-word frame, header first, gap >= 170
    fA(24'hA1B2C3); fA(24'h0D0E0F);
    eA(24'hA1B2C3); eA(24'h0D0E0F);
    pulseA();
    chk("A_busy_up", busyA, 1);
    repeat (300) @(negedge clk);
    startA = 1;
    @(negedge clk);
    startA = 0;
    idleA_wait("A_f1_end");
    chk("A_f1_done", dcA, 1);
    chk("A_f1_rd", rdcA, 2);
    chk("A_f1_wrs", wrcA, 8);
    chk("A_f1_wcnt", wcA, 2);
    chk("A_f1_uf", ufA, 0);
    chk("A_f1_sb", sbA.size(), 0);

    // A: abort during the second byte of the first word
    fA(24'h112233); fA(24'h445566);
    eA(24'h112233);
    r0 = rdcA; d0 = dcA;
    pulseA();
    wrA_wait("A_ab_wr2", 2);
    abortA = 1;
    idleA_wait("A_ab_end");
    abortA = 0;
    chk("A_ab_done", dcA, d0);
    chk("A_ab_wcnt", wcA, 1);
    chk("A_ab_busy", busyA, 0);
    chk("A_ab_rd", rdcA - r0, 1);
    chk("A_ab_left", pushA - popA, 1);
    chk("A_ab_sb", sbA.size(), 0);

    // A: reset in S_WAIT, leftover word 445566 is in flight
    sbA.push_back(8'h55);
    sbA.push_back(8'h44);
    pulseA();
    wrA_wait("A_rs_wr2", 2);
    rst = 0;
    #1;
    chk("A_rs_busy", busyA, 0);
    chk("A_rs_wrsig", wrA, 0);
    chk("A_rs_txdata", txA, 0);
    chk("A_rs_wcnt", wcA, 0);
    chk("A_rs_rdreq", rdA, 0);
    chk("A_rs_done", doneA, 0);
    sbA.delete();
    repeat (2) @(negedge clk);
    rst = 1;
    d0 = dcA;
    fA(24'h123456); fA(24'h789ABC);
    eA(24'h123456); eA(24'h789ABC);
    pulseA();
    idleA_wait("A_rs_end");
    chk("A_rs_done_n", dcA - d0, 1);
    chk("A_rs_wcnt2", wcA, 2);
    chk("A_rs_sb", sbA.size(), 0);

    // B: no header, FIFO stall after word 1
    wB(32'h11223344);
    pulseB();
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (wcB == 16'd1) break;
    end
    chk("B_w1", wcB, 1);
    w0 = wrcB;
    repeat (500) @(negedge clk);
    chk("B_stall_wr", wrcB - w0, 0);
    chk("B_stall_uf", ufB, 1);
    chk("B_stall_busy", busyB, 1);
    wB(32'h55667788); wB(32'h99AABBCC);
    idleB_wait("B_f1_end");
    chk("B_f1_done", dcB, 1);
    chk("B_f1_wcnt", wcB, 3);
    chk("B_f1_uf", ufB, 1);
    chk("B_f1_rd", rdcB, 3);
    chk("B_f1_sb", sbB.size(), 0);

    // B: start clears sticky underflow
    wB(32'hDEADBEEF); wB(32'h01020304); wB(32'hF0E0D0C0);
    pulseB();
    chk("B_f2_uf", ufB, 0);
    idleB_wait("B_f2_end");
    chk("B_f2_done", dcB, 2);
    chk("B_f2_wcnt", wcB, 3);
    chk("B_f2_uf_end", ufB, 0);
    chk("B_f2_sb", sbB.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
